// File: rtl/branch_predict_unit.sv
// Branch resolution plus BTB direction/target prediction (direct-mapped, 2-bit counters).
// Optional statistics counters are built when BPU_STATS_EN is defined.
module branch_predict_unit #(
  parameter int PC_W      = 9,
  parameter int BTB_DEPTH = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PC_W-1:0] if_pc,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_target,
  input  logic            ex_valid,
  input  logic            ex_stall,
  input  logic [PC_W-1:0] ex_pc,
  input  logic [31:0]     ex_imm,
  input  logic            ex_branch,
  input  logic            ex_force_branch,
  input  logic [31:0]     ex_alu_result,
  input  logic            ex_pred_taken,
  input  logic [PC_W-1:0] ex_pred_target,
  output logic [31:0]     pc_imm,
  output logic [31:0]     pc_four,
  output logic            mispredict,
  output logic [31:0]     redirect_pc,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
);

  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = PC_W - IDX_W - 2;

  logic [BTB_DEPTH-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]     tag_q [BTB_DEPTH];
  logic [TAG_W-1:0]     tag_d [BTB_DEPTH];
  logic [1:0]           ctr_q [BTB_DEPTH];
  logic [1:0]           ctr_d [BTB_DEPTH];
  logic [PC_W-1:0]      tgt_q [BTB_DEPTH];
  logic [PC_W-1:0]      tgt_d [BTB_DEPTH];

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  logic             if_hit, ex_hit;
  logic [31:0]      ex_pc_ext;
  logic             act_taken;
  logic             upd_en;
  logic             unused_alu;

  assign unused_alu = ^ex_alu_result[31:1];

  // Fetch-side lookup, combinational
  assign if_idx      = if_pc[IDX_W+1:2];
  assign if_tag      = if_pc[PC_W-1:IDX_W+2];
  assign if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign pred_taken  = !reset && if_hit && ctr_q[if_idx][1];
  assign pred_target = pred_taken ? tgt_q[if_idx] : '0;

  // Execute-side resolution
  assign ex_pc_ext   = {{(32-PC_W){1'b0}}, ex_pc};
  assign pc_imm      = ex_pc_ext + ex_imm;
  assign pc_four     = ex_pc_ext + 32'd4;
  assign act_taken   = (ex_branch && ex_alu_result[0]) || ex_force_branch;
  assign redirect_pc = act_taken ? pc_imm : pc_four;
  assign mispredict  = !reset && ex_valid &&
                       ((act_taken != ex_pred_taken) ||
                        (act_taken && (ex_pred_target != pc_imm[PC_W-1:0])));

  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_tag = ex_pc[PC_W-1:IDX_W+2];
  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
  assign upd_en = !reset && ex_valid && !ex_stall && (ex_branch || ex_force_branch);

  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < BTB_DEPTH; i++) begin
      tag_d[i] = tag_q[i];
      ctr_d[i] = ctr_q[i];
      tgt_d[i] = tgt_q[i];
    end
    if (upd_en) begin
      if (ex_hit) begin
        if (act_taken) begin
          ctr_d[ex_idx] = (ctr_q[ex_idx] == 2'b11) ? 2'b11 : ctr_q[ex_idx] + 2'd1;
          tgt_d[ex_idx] = pc_imm[PC_W-1:0];
        end else begin
          ctr_d[ex_idx] = (ctr_q[ex_idx] == 2'b00) ? 2'b00 : ctr_q[ex_idx] - 2'd1;
        end
        if (ex_force_branch) ctr_d[ex_idx] = 2'b11;
      end else if (act_taken) begin
        // Miss on a taken branch: overwrite whatever lived at this index
        valid_d[ex_idx] = 1'b1;
        tag_d[ex_idx]   = ex_tag;
        tgt_d[ex_idx]   = pc_imm[PC_W-1:0];
        ctr_d[ex_idx]   = ex_force_branch ? 2'b11 : 2'b10;
      end
    end
  end

  // Only the valid bits need resetting; stale payload is masked by valid
  always_ff @(posedge clk) begin
    if (reset) valid_q <= '0;
    else       valid_q <= valid_d;
    for (int i = 0; i < BTB_DEPTH; i++) begin
      tag_q[i] <= tag_d[i];
      ctr_q[i] <= ctr_d[i];
      tgt_q[i] <= tgt_d[i];
    end
  end

`ifdef BPU_STATS_EN
  logic [31:0] stat_br_q, stat_br_d;
  logic [31:0] stat_mp_q, stat_mp_d;

  always_comb begin
    stat_br_d = stat_br_q;
    stat_mp_d = stat_mp_q;
    if (upd_en && (stat_br_q != 32'hFFFF_FFFF)) stat_br_d = stat_br_q + 32'd1;
    if (upd_en && mispredict && (stat_mp_q != 32'hFFFF_FFFF)) stat_mp_d = stat_mp_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      stat_br_q <= stat_br_d;
      stat_mp_q <= stat_mp_d;
    end
  end

  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mp_q;
`else
  assign stat_branches    = 32'b0;
  assign stat_mispredicts = 32'b0;
`endif

endmodule
